// File: rtl/fracnet_mul_share_ctrl.sv
// Round-robin scheduler sharing one signed A x B multiplier between NUM_REQ requesters.
// Operands are registered in S1. The product is registered in S2 and returned with the requester tag.
module fracnet_mul_share_ctrl #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = 2,
  parameter int A_WIDTH  = 16,
  parameter int B_WIDTH  = 9,
  parameter int P_WIDTH  = 26
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0] req_b,
  output logic [A_WIDTH-1:0]         mul_din0,
  output logic [B_WIDTH-1:0]         mul_din1,
  input  logic [P_WIDTH-1:0]         mul_dout,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [P_WIDTH-1:0]         out_p,
  output logic [ID_WIDTH-1:0]        out_id,
  output logic                       busy
);

  logic                s1_valid_q, s1_valid_d;
  logic [ID_WIDTH-1:0] s1_id_q, s1_id_d;
  logic [A_WIDTH-1:0]  s1_a_q, s1_a_d;
  logic [B_WIDTH-1:0]  s1_b_q, s1_b_d;
  logic                s2_valid_q, s2_valid_d;
  logic [P_WIDTH-1:0]  s2_p_q, s2_p_d;
  logic [ID_WIDTH-1:0] s2_id_q, s2_id_d;
  logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;

  logic                adv1;
  logic                adv2;
  logic                grant_found;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_WIDTH-1:0] grant_id;
  logic [ID_WIDTH-1:0] grant_next;
  logic [A_WIDTH-1:0]  grant_a;
  logic [B_WIDTH-1:0]  grant_b;

  assign adv2 = !s2_valid_q || out_ready;
  assign adv1 = !s1_valid_q || adv2;

  // Scan distance k from rr_ptr. Requester j wins at the first k where it sits at rr_ptr+k, taken modulo NUM_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant       = '0;
    grant_id    = '0;
    grant_next  = '0;
    grant_a     = '0;
    grant_b     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!grant_found && req_valid[j] &&
            ((int'(rr_ptr_q) + k == j) || (int'(rr_ptr_q) + k == j + NUM_REQ))) begin
          grant_found = 1'b1;
          grant[j]    = 1'b1;
          grant_id    = ID_WIDTH'(j);
          grant_next  = (j == NUM_REQ - 1) ? '0 : ID_WIDTH'(j + 1);
          grant_a     = req_a[j*A_WIDTH +: A_WIDTH];
          grant_b     = req_b[j*B_WIDTH +: B_WIDTH];
        end
      end
    end
  end

  assign req_ready = (adv1 && !ap_rst) ? grant : '0;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_id_d    = s1_id_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    rr_ptr_d   = rr_ptr_q;
    s2_valid_d = s2_valid_q;
    s2_p_d     = s2_p_q;
    s2_id_d    = s2_id_q;

    if (adv1) begin
      s1_valid_d = grant_found;
      if (grant_found) begin
        s1_id_d  = grant_id;
        s1_a_d   = grant_a;
        s1_b_d   = grant_b;
        rr_ptr_d = grant_next;
      end
    end

    // The multiplier is combinational on the S1 operands, so S2 captures its result directly.
    if (adv2) begin
      s2_valid_d = s1_valid_q;
      s2_p_d     = mul_dout;
      s2_id_d    = s1_id_q;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      s1_valid_q <= 1'b0;
      s1_id_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_p_q     <= '0;
      s2_id_q    <= '0;
      rr_ptr_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_id_q    <= s1_id_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s2_valid_q <= s2_valid_d;
      s2_p_q     <= s2_p_d;
      s2_id_q    <= s2_id_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign mul_din0  = s1_a_q;
  assign mul_din1  = s1_b_q;
  assign out_valid = s2_valid_q;
  assign out_p     = s2_p_q;
  assign out_id    = s2_id_q;
  assign busy      = s1_valid_q || s2_valid_q;

endmodule

// File: tb/tb_fracnet_mul_share_ctrl.sv
// Self-checking bench for fracnet_mul_share_ctrl: table vectors, directed corner sequences,
// and random traffic compared against an in-flight queue model of the scheduler.
module tb_fracnet_mul_share_ctrl;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int AW = 16;
  localparam int BW = 9;
  localparam int PW = 26;

  logic            ap_clk = 1'b0;
  logic            ap_rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_a;
  logic [N*BW-1:0] req_b;
  logic [AW-1:0]   mul_din0;
  logic [BW-1:0]   mul_din1;
  logic [PW-1:0]   mul_dout;
  logic            out_valid;
  logic            out_ready;
  logic [PW-1:0]   out_p;
  logic [IW-1:0]   out_id;
  logic            busy;

  always #5 ap_clk = ~ap_clk;

  fracnet_mul_share_ctrl #(
    .NUM_REQ(N), .ID_WIDTH(IW), .A_WIDTH(AW), .B_WIDTH(BW), .P_WIDTH(PW)
  ) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .out_id(out_id), .busy(busy)
  );

  // Behavioural stand-in for the shared DSP multiplier.
  logic signed [PW-1:0] mul_a_ext;
  logic signed [PW-1:0] mul_b_ext;
  assign mul_a_ext = PW'($signed(mul_din0));
  assign mul_b_ext = PW'($signed(mul_din1));
  assign mul_dout  = mul_a_ext * mul_b_ext;

  typedef struct {
    int p;
    int id;
    bit at_out;
  } op_t;

  typedef struct {
    int id;
    int a;
    int b;
    int p;
  } vec_t;

  op_t          q[$];
  int           rr;
  int           checks = 0;
  int           errors = 0;
  int           delivered = 0;
  logic [N-1:0] last_ready;
  logic [N*AW-1:0] a_bus;
  logic [N*BW-1:0] b_bus;
  bit           m_out_valid;
  bit           m_allow;
  bit           m_found;
  int           m_grant;

  task automatic compare(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int sa(input int i);
    logic signed [AW-1:0] v;
    v = req_a[i*AW +: AW];
    return int'(v);
  endfunction

  function automatic int sb(input int i);
    logic signed [BW-1:0] v;
    v = req_b[i*BW +: BW];
    return int'(v);
  endfunction

  task automatic setOperands(input int id, input int a, input int b);
    a_bus[id*AW +: AW] = AW'(a);
    b_bus[id*BW +: BW] = BW'(b);
  endtask

  // Compare the DUT with the model for the current inputs. Expected values are derived from the in-flight queue and the round-robin pointer.
  task automatic checkOutput();
    logic [N-1:0] exp_ready;
    m_out_valid = (q.size() > 0) && q[0].at_out;
    m_allow     = !ap_rst && !(q.size() == 2 && !out_ready);
    m_found     = 1'b0;
    m_grant     = 0;
    for (int k = 0; k < N; k++) begin
      if (!m_found && req_valid[(rr + k) % N]) begin
        m_found = 1'b1;
        m_grant = (rr + k) % N;
      end
    end
    exp_ready = '0;
    if (m_allow && m_found) exp_ready[m_grant] = 1'b1;
    last_ready = req_ready;
    compare("req_ready", req_ready, exp_ready);
    compare("out_valid", out_valid, m_out_valid);
    compare("busy", busy, q.size() > 0);
    if (m_out_valid) begin
      compare("out_p", $signed(out_p), q[0].p);
      compare("out_id", out_id, q[0].id);
    end
  endtask

  task automatic modelEdge();
    op_t n;
    if (ap_rst) begin
      q.delete();
      rr = 0;
      return;
    end
    if (m_out_valid && out_ready) begin
      void'(q.pop_front());
      delivered++;
    end
    if (q.size() > 0 && !q[0].at_out) q[0].at_out = 1'b1;
    if (m_allow && m_found) begin
      n.p      = sa(m_grant) * sb(m_grant);
      n.id     = m_grant;
      n.at_out = 1'b0;
      q.push_back(n);
      rr = (m_grant + 1) % N;
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] v, input logic ordy);
    req_valid = v;
    req_a     = a_bus;
    req_b     = b_bus;
    out_ready = ordy;
    #1;
    checkOutput();
    modelEdge();
    @(posedge ap_clk);
    #1;
  endtask

  vec_t vecs[6];

  initial begin
    int base;
    logic [N-1:0] rv;
    int sent;
    logic [PW-1:0] held_p;
    logic [IW-1:0] held_id;

    vecs[0] = '{1, 100, -3, -300};
    vecs[1] = '{0, -32768, -256, 8388608};
    vecs[2] = '{0, 32767, 255, 8355585};
    vecs[3] = '{0, -32768, 255, -8355840};
    vecs[4] = '{2, 12345, -100, -1234500};
    vecs[5] = '{3, -1, -1, 1};

    ap_rst    = 1'b1;
    req_valid = '1;
    a_bus     = '0;
    b_bus     = '0;
    req_a     = '0;
    req_b     = '0;
    out_ready = 1'b1;
    rr        = 0;
    repeat (2) @(posedge ap_clk);
    #1;
    compare("rst_req_ready", req_ready, 0);
    compare("rst_out_valid", out_valid, 0);
    compare("rst_busy", busy, 0);
    compare("rst_din0", mul_din0, 0);
    compare("rst_din1", mul_din1, 0);
    compare("rst_out_p", out_p, 0);
    compare("rst_out_id", out_id, 0);
    ap_rst = 1'b0;
    applyStimulus('0, 1'b1);

    // Single operations from the table. Each result must appear two edges after acceptance.
    for (int i = 0; i < 6; i++) begin
      setOperands(vecs[i].id, vecs[i].a, vecs[i].b);
      applyStimulus(N'(1) << vecs[i].id, 1'b1);
      compare("vec_ready", last_ready, N'(1) << vecs[i].id);
      applyStimulus('0, 1'b1);
      compare("vec_valid", out_valid, 1);
      compare("vec_p", $signed(out_p), vecs[i].p);
      compare("vec_id", out_id, vecs[i].id);
      applyStimulus('0, 1'b1);
      applyStimulus('0, 1'b1);
    end

    // All requesters continuously valid: the grant rotates 0,1,2,3 and out_id follows one cycle later.
    for (int i = 0; i < N; i++) setOperands(i, 50 * i + 7, 3 - i);
    for (int c = 0; c < 8; c++) begin
      applyStimulus('1, 1'b1);
      compare("rr_grant", last_ready, N'(1) << (c % N));
      if (c >= 1) compare("rr_out_id", out_id, (c - 1) % N);
    end
    applyStimulus('0, 1'b1);
    applyStimulus('0, 1'b1);

    // Fairness: move rr_ptr to 1, then requesters 0 and 2 must alternate starting with 2.
    applyStimulus(4'b0001, 1'b1);
    applyStimulus('0, 1'b1);
    applyStimulus('0, 1'b1);
    for (int c = 0; c < 4; c++) begin
      applyStimulus(4'b0101, 1'b1);
      compare("fair_grant", last_ready, (c % 2 == 0) ? 4'b0100 : 4'b0001);
    end
    applyStimulus('0, 1'b1);
    applyStimulus('0, 1'b1);

    // Backpressure: six ops from requester 1, with the output stalled for three cycles.
    base   = delivered;
    sent   = 0;
    held_p = '0;
    held_id = '0;
    setOperands(1, 311 - 900, -100);
    for (int c = 0; c < 20; c++) begin
      if (c == 3) begin
        held_p  = out_p;
        held_id = out_id;
      end
      applyStimulus((sent < 6) ? 4'b0010 : 4'b0000, !(c >= 3 && c <= 5));
      if (c >= 3 && c <= 5) begin
        compare("bp_hold_p", out_p, held_p);
        compare("bp_hold_id", out_id, held_id);
        compare("bp_no_ready", last_ready, 0);
      end
      if (last_ready[1]) begin
        sent++;
        setOperands(1, (sent + 1) * 311 - 900, sent * 37 - 100);
      end
    end
    compare("bp_delivered", delivered - base, 6);

    // Reset with two operations in flight discards both and returns rr_ptr to 0.
    setOperands(2, 1234, 56);
    applyStimulus(4'b0100, 1'b0);
    applyStimulus(4'b0100, 1'b0);
    compare("pre_rst_busy", busy, 1);
    ap_rst = 1'b1;
    applyStimulus('1, 1'b1);
    compare("rst_mid_valid", out_valid, 0);
    compare("rst_mid_busy", busy, 0);
    ap_rst = 1'b0;
    applyStimulus('0, 1'b1);
    applyStimulus('0, 1'b1);
    setOperands(0, -77, 13);
    applyStimulus('1, 1'b1);
    compare("rst_rr_zero", last_ready, 4'b0001);
    applyStimulus('0, 1'b1);
    compare("post_rst_p", $signed(out_p), -1001);
    applyStimulus('0, 1'b1);
    applyStimulus('0, 1'b1);

    // Random traffic. Requests are held until accepted, with occasional withdrawal.
    rv = '0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!rv[i] && ($urandom % 3 == 0)) begin
          rv[i] = 1'b1;
          if ($urandom % 8 == 0)
            setOperands(i, ($urandom % 2) ? -32768 : 32767, ($urandom % 2) ? -256 : 255);
          else
            setOperands(i, int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 511)) - 256);
        end else if (rv[i] && ($urandom % 16 == 0)) begin
          rv[i] = 1'b0;
        end
      end
      applyStimulus(rv, ($urandom % 4) != 0);
      rv = rv & ~last_ready;
    end

    for (int c = 0; c < 4; c++) applyStimulus('0, 1'b1);
    compare("drain_busy", busy, 0);
    compare("drain_queue", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fracnet_mul_share_ctrl.md
Name: fracnet_mul_share_ctrl

Overview:
- Round-robin scheduler that time-shares one signed 16x9 DSP multiplier (26-bit product) between NUM_REQ requesters in the FracNet datapath.
- Arbitrates operand requests and drives the multiplier's din0/din1 from registered operands.
- Registers the product and returns it tagged with the requester index over a valid/ready output with backpressure.
- Sustains one multiply per cycle with a fixed 2-cycle latency when not stalled.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_WIDTH, 2, width of requester tag; must be >= ceil(log2(NUM_REQ)).
- A_WIDTH, 16, signed operand A width (multiplier din0).
- B_WIDTH, 9, signed operand B width (multiplier din1).
- P_WIDTH, 26, signed product width (multiplier dout).

Ports:
- ap_clk  in  1  clock; all state updates on rising edge.
- ap_rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high per cycle.
- req_a  in  NUM_REQ*A_WIDTH  packed signed operand A; requester i occupies bits [i*A_WIDTH +: A_WIDTH].
- req_b  in  NUM_REQ*B_WIDTH  packed signed operand B; same packing as req_a.
- mul_din0  out  A_WIDTH  operand A to the shared multiplier (S1 register).
- mul_din1  out  B_WIDTH  operand B to the shared multiplier (S1 register).
- mul_dout  in  P_WIDTH  combinational signed product from the multiplier.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- out_p  out  P_WIDTH  signed product.
- out_id  out  ID_WIDTH  requester index of out_p.
- busy  out  1  s1_valid | s2_valid.

Behaviour:
- Reset values: s1_valid=0, s2_valid=0, mul_din0=0, mul_din1=0, out_p=0, out_id=0, rr_ptr=0.
- Reset outputs: req_ready=0 while ap_rst=1; busy=0.
- Reset mid-operation: all in-flight operations are discarded. No result appears after reset release.
- Pipeline: S1 holds the operand register, tag and s1_valid; the multiplier is combinational on S1. S2 holds out_p, out_id and out_valid (s2_valid).
- adv2 = !s2_valid | out_ready.
  - S2 loads from S1 (mul_dout, s1 tag, s1_valid) when adv2.
  - Otherwise S2 holds all values stable.
- adv1 = !s1_valid | adv2. A new request is accepted only when adv1.
- Arbitration: the grant goes to the first i with req_valid[i], scanning from rr_ptr upward modulo NUM_REQ.
  - req_ready[i] = grant[i] & adv1 & !ap_rst.
  - A transfer occurs when req_valid[i] & req_ready[i].
  - On transfer: S1 takes req_a[i] and req_b[i], tag=i, s1_valid=1, and rr_ptr becomes (i+1) mod NUM_REQ.
  - With no transfer, rr_ptr is unchanged. If adv1 and there is no transfer, s1_valid becomes 0.
- Requester rules: a requester must hold valid and data stable until it is accepted. Deasserting valid before acceptance is allowed and simply withdraws the request; it is not an error.
- Latency: a transfer at edge k gives out_valid=1 after edge k+1, with out_p = req_a*req_b. There are no stalls in this path.
- Throughput: one result per cycle while out_ready=1.
- Result ordering: results leave in acceptance order. No result is lost or duplicated.
- Arithmetic: full signed product of A_WIDTH x B_WIDTH, sign-extended to P_WIDTH. It cannot overflow (range -8355840..8388608).
- Backpressure: when out_valid=1 and out_ready=0, out_p and out_id stay stable.
  - If S1 is also full, req_ready=0 for all requesters.
  - At most 2 results are in flight.
- Simultaneous events: when out_ready=1 with both stages full, S2 drains, S1 moves to S2 and a new request is accepted in the same cycle.
- Single requester: a lone continuously valid requester is granted every cycle.

Test Plan:
- Single op: requester 1 with a=100, b=-3 -> req_ready[1] pulses 1 cycle; out_valid 2 cycles later with out_p=-300 (26'h3FFFED4), out_id=1; busy high for the in-flight cycles.
- Extremes, one op each, on requester 0:
  - a=-32768, b=-256 -> out_p=8388608.
  - a=32767, b=255 -> out_p=8355585.
  - a=-32768, b=255 -> out_p=-8355840.
- All 4 requesters continuously valid, out_ready=1 -> grants 0,1,2,3,0,1,... one per cycle; out_id follows the same sequence.
- Fairness: only requesters 0 and 2 valid, rr_ptr=1 -> grant 2, then 0, then 2 (strict alternation).
- Backpressure: a stream of 6 ops with out_ready low for 3 cycles mid-stream -> out_p/out_id held stable; all req_ready low once 2 ops are in flight; all 6 results delivered in order with no duplicates.
- Reset mid-op: assert ap_rst for 1 cycle with 2 ops in flight -> out_valid=0, busy=0 and rr_ptr=0 after the edge; no stale result after release; the next op completes normally.
